// File: rtl/seq_event_counter.sv
// Run-event counter fed by a detector level output: one Pulse per z-high run,
// saturating run count with sticky overflow, and run-length measurement.
// Optional `MAX_RUN_EN adds a MaxRun output holding the longest run since reset/Clear.
module seq_event_counter #(
    parameter int unsigned CW = 8,
    parameter int unsigned RW = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          z,
    input  logic          Clear,
    output logic          Pulse,
    output logic          Active,
    output logic [CW-1:0] Count,
    output logic [RW-1:0] RunLen,
`ifdef MAX_RUN_EN
    output logic [RW-1:0] MaxRun,
`endif
    output logic          Ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        RUN   = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic            pulse_q, active_q;
    logic [CW-1:0]   count_q, count_d;
    logic [RW-1:0]   runlen_q, runlen_d;
    logic            ovf_q, ovf_d;
    logic [RW-1:0]   maxrun_q, maxrun_d;
    logic            start_c;

    // Next-state and counter update; Clear overrides counters but never the FSM.
    always_comb begin
        state_d  = IDLE;
        count_d  = count_q;
        runlen_d = runlen_q;
        ovf_d    = ovf_q;
        maxrun_d = maxrun_q;
        start_c  = 1'b0;

        case (state_q)
            IDLE:       state_d = z ? START : IDLE;
            START, RUN: state_d = z ? RUN : IDLE;
            default:    state_d = IDLE;
        endcase

        start_c = (state_q == IDLE) && z;

        if (start_c) begin
            if (count_q == {CW{1'b1}}) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
            runlen_d = RW'(1);
        end else if (((state_q == START) || (state_q == RUN)) && z
                     && (runlen_q != {RW{1'b1}})) begin
            runlen_d = runlen_q + RW'(1);
        end

        if (runlen_d > maxrun_q) begin
            maxrun_d = runlen_d;
        end

        if (Clear) begin
            count_d  = '0;
            runlen_d = '0;
            ovf_d    = 1'b0;
            maxrun_d = '0;
        end
    end

    // Pulse/Active are registered from the next state so they match the Moore decode.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            pulse_q  <= 1'b0;
            active_q <= 1'b0;
            count_q  <= '0;
            runlen_q <= '0;
            ovf_q    <= 1'b0;
            maxrun_q <= '0;
        end else begin
            state_q  <= state_d;
            pulse_q  <= (state_d == START);
            active_q <= (state_d != IDLE);
            count_q  <= count_d;
            runlen_q <= runlen_d;
            ovf_q    <= ovf_d;
            maxrun_q <= maxrun_d;
        end
    end

    assign Pulse  = pulse_q;
    assign Active = active_q;
    assign Count  = count_q;
    assign RunLen = runlen_q;
    assign Ovf    = ovf_q;
`ifdef MAX_RUN_EN
    assign MaxRun = maxrun_q;
`endif

endmodule

// File: tb/tb_seq_event_counter.sv
// Scoreboard bench for seq_event_counter (CW=4, RW=4); MaxRun checks follow `MAX_RUN_EN.
module tb_seq_event_counter;

    logic       clk;
    logic       rst_n;
    logic       z;
    logic       clr;
    logic       pulse, active, ovf;
    logic [3:0] count, runlen;
`ifdef MAX_RUN_EN
    logic [3:0] maxrun;
`endif

    int unsigned n_cmp;
    int unsigned n_err;

    typedef struct {
        int unsigned pulse;
        int unsigned active;
        int unsigned count;
        int unsigned runlen;
        int unsigned ovf;
        int unsigned maxrun;
    } exp_t;

    exp_t exp_q[$];

    // Reference model expressed as run semantics rather than FSM states.
    int unsigned m_pulse, m_active, m_count, m_runlen, m_ovf, m_max;

    seq_event_counter #(.CW(4), .RW(4)) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .z      (z),
        .Clear  (clr),
        .Pulse  (pulse),
        .Active (active),
        .Count  (count),
        .RunLen (runlen),
`ifdef MAX_RUN_EN
        .MaxRun (maxrun),
`endif
        .Ovf    (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pulse = 0; m_active = 0; m_count = 0; m_runlen = 0; m_ovf = 0; m_max = 0;
    endtask

    task automatic model_edge(input bit zv, input bit cv);
        bit started;
        started = zv && (m_active == 0);
        if (started) begin
            if (m_count == 15) m_ovf = 1;
            else m_count++;
            m_runlen = 1;
        end else if (zv && m_runlen < 15) begin
            m_runlen++;
        end
        if (m_runlen > m_max) m_max = m_runlen;
        m_pulse  = started ? 1 : 0;
        m_active = zv ? 1 : 0;
        if (cv) begin
            m_count = 0; m_runlen = 0; m_ovf = 0; m_max = 0;
        end
    endtask

    // One clock: drive on negedge, predict, push; sample after posedge, pop, compare.
    task automatic step(input bit zv, input bit cv);
        exp_t e;
        @(negedge clk);
        z   = zv;
        clr = cv;
        model_edge(zv, cv);
        e.pulse  = m_pulse;
        e.active = m_active;
        e.count  = m_count;
        e.runlen = m_runlen;
        e.ovf    = m_ovf;
        e.maxrun = m_max;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val("pulse",  32'(pulse),  e.pulse);
            check_val("active", 32'(active), e.active);
            check_val("count",  32'(count),  e.count);
            check_val("runlen", 32'(runlen), e.runlen);
            check_val("ovf",    32'(ovf),    e.ovf);
`ifdef MAX_RUN_EN
            check_val("maxrun", 32'(maxrun), e.maxrun);
`endif
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_pulse"},  32'(pulse),  32'd0);
        check_val({tag, "_active"}, 32'(active), 32'd0);
        check_val({tag, "_count"},  32'(count),  32'd0);
        check_val({tag, "_runlen"}, 32'(runlen), 32'd0);
        check_val({tag, "_ovf"},    32'(ovf),    32'd0);
`ifdef MAX_RUN_EN
        check_val({tag, "_maxrun"}, 32'(maxrun), 32'd0);
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        z     = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #23;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single run of three: one Pulse, Active for three cycles, RunLen held.
        step(1, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        check_val("run3_count",  32'(count),  32'd1);
        check_val("run3_runlen", 32'(runlen), 32'd3);

        // Alternating z: every 1 is its own run.
        step(0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            step(0, 0);
        end
        check_val("alt_count",  32'(count),  32'd3);
        check_val("alt_runlen", 32'(runlen), 32'd1);

        // Count saturation and sticky overflow, then Clear.
        step(0, 1);
        for (int i = 0; i < 16; i++) begin
            step(1, 0);
            step(0, 0);
        end
        check_val("sat_count", 32'(count), 32'd15);
        check_val("sat_ovf",   32'(ovf),    32'd1);
        step(0, 0);
        check_val("sticky_ovf", 32'(ovf), 32'd1);
        step(0, 1);
        check_val("clr_count",  32'(count),  32'd0);
        check_val("clr_ovf",    32'(ovf),    32'd0);
        check_val("clr_runlen", 32'(runlen), 32'd0);

        // Long run saturates RunLen without touching Ovf.
        for (int i = 0; i < 20; i++) step(1, 0);
        step(0, 0);
        check_val("long_runlen", 32'(runlen), 32'd15);
        check_val("long_ovf",    32'(ovf),    32'd0);
        check_val("long_count",  32'(count),  32'd1);

        // Back-to-back runs separated by a single z=0 are distinct.
        step(0, 1);
        step(1, 0); step(1, 0); step(0, 0); step(1, 0); step(1, 0); step(0, 0);
        check_val("b2b_count", 32'(count), 32'd2);

`ifdef MAX_RUN_EN
        // MaxRun tracks the longest run; Clear on a run start wins but Pulse still fires.
        step(0, 1);
        for (int i = 0; i < 4; i++) step(1, 0);
        step(0, 0);
        check_val("max_4", 32'(maxrun), 32'd4);
        for (int i = 0; i < 2; i++) step(1, 0);
        step(0, 0);
        check_val("max_2", 32'(maxrun), 32'd4);
        for (int i = 0; i < 6; i++) step(1, 0);
        step(0, 0);
        check_val("max_6", 32'(maxrun), 32'd6);
        step(1, 1);
        check_val("clrstart_pulse",  32'(pulse),  32'd1);
        check_val("clrstart_count",  32'(count),  32'd0);
        check_val("clrstart_runlen", 32'(runlen), 32'd0);
        check_val("clrstart_maxrun", 32'(maxrun), 32'd0);
        step(1, 0);
        check_val("clrstart_pulse2", 32'(pulse), 32'd0);
        step(0, 0);
`else
        // Clear coincident with a run start: counters zero, Pulse still fires.
        step(0, 0);
        step(1, 1);
        check_val("clrstart_pulse", 32'(pulse), 32'd1);
        check_val("clrstart_count", 32'(count), 32'd0);
        step(0, 0);
`endif

        // Asynchronous reset in the middle of a run with Count=5.
        step(0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0);
            step(0, 0);
        end
        step(1, 0); step(1, 0);
        check_val("pre_rst_count",  32'(count),  32'd5);
        check_val("pre_rst_active", 32'(active), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("async_rst");
        rst_n = 1'b1;
        step(0, 0);
        step(1, 0);
        check_val("post_rst_pulse", 32'(pulse), 32'd1);
        check_val("post_rst_count", 32'(count), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
        end
        step(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
